// File: rtl/gcd_pkg.sv
//------------------------------------------------------------------
// gcd_pkg : shared state encoding and default sizes for the GCD scheduler
// Revision : 1.0
//------------------------------------------------------------------
`default_nettype none

package gcd_pkg;

  localparam int DEFAULT_WIDTH    = 32;
  localparam int DEFAULT_MAX_ITER = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/gcd_step_core.sv
//------------------------------------------------------------------
// gcd_step_core : Euclid datapath, one modulo step per enabled cycle
// Revision : 1.0
//------------------------------------------------------------------
`default_nettype none

module gcd_step_core
  import gcd_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_ITER = DEFAULT_MAX_ITER,
  parameter int IW       = $clog2(MAX_ITER + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] a_o,
  output logic             b_zero_o,
  output logic             iter_max_o
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    iter_q;
  logic [WIDTH-1:0] mod_d;

  // Divisor guard keeps the modulo defined even when no step is taken.
  assign mod_d      = (b_q == '0) ? '0 : (a_q % b_q);
  assign b_zero_o   = (b_q == '0);
  assign iter_max_o = (iter_q == IW'(MAX_ITER));
  assign a_o        = a_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      iter_q <= '0;
    end else if (load_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      iter_q <= '0;
    end else if (step_i) begin
      a_q    <= b_q;
      b_q    <= mod_d;
      iter_q <= iter_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gcd_rr_sched.sv
//------------------------------------------------------------------
// gcd_rr_sched : round-robin shared GCD engine with per-requester handshakes
// Revision : 1.0
//------------------------------------------------------------------
`default_nettype none

module gcd_rr_sched
  import gcd_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_ITER = DEFAULT_MAX_ITER
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_gcd,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [15:0]           done_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state_q;
  logic [PW-1:0]    rr_ptr_q;
  logic [PW-1:0]    owner_q;
  logic             err_q;
  logic [15:0]      done_cnt_q;

  logic [PW-1:0]    grant_d;
  logic             grant_vld_d;
  logic             load_d;
  logic             step_d;
  logic             rsp_fire_d;
  logic             b_zero;
  logic             iter_max;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_split
    assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
    assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
  end

  // Scan from the far end back toward rr_ptr so the nearest valid wins.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_v;
    grant_vld_d = 1'b0;
    grant_d     = rr_ptr_q;
    idx         = 0;
    idx_v       = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx   = (int'(rr_ptr_q) + off) % NREQ;
      idx_v = PW'(idx);
      if (req_valid[idx_v]) begin
        grant_vld_d = 1'b1;
        grant_d     = idx_v;
      end
    end
  end

  assign load_d     = (state_q == IDLE) && grant_vld_d;
  assign step_d     = (state_q == RUN) && !b_zero && !iter_max;
  assign rsp_fire_d = (state_q == RESP) && rsp_ready[owner_q];

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (load_d) req_ready[grant_d] = 1'b1;
    if (state_q == RESP) rsp_valid[owner_q] = 1'b1;
  end

  gcd_step_core #(
    .WIDTH    (WIDTH),
    .MAX_ITER (MAX_ITER)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_d),
    .step_i     (step_d),
    .a_i        (a_arr[grant_d]),
    .b_i        (b_arr[grant_d]),
    .a_o        (core_a),
    .b_zero_o   (b_zero),
    .iter_max_o (iter_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      err_q      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            owner_q <= grant_d;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Zero divisor takes precedence over the cap on the same cycle.
          if (b_zero) begin
            err_q   <= 1'b0;
            state_q <= RESP;
          end else if (iter_max) begin
            err_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_fire_d) begin
            rr_ptr_q   <= (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            done_cnt_q <= done_cnt_q + 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_gcd  = core_a;
  assign rsp_err  = err_q;
  assign busy     = (state_q != IDLE);
  assign done_cnt = done_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_gcd_rr_sched.sv
//------------------------------------------------------------------
// tb_gcd_rr_sched : directed and random jobs against an arithmetic GCD model
// Revision : 1.0
//------------------------------------------------------------------
`default_nettype none

module tb_gcd_rr_sched;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MI = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [W-1:0]    rsp_gcd;
  logic            rsp_err;
  logic            busy;
  logic [15:0]     done_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          m_ptr   = 0;
  logic [15:0] m_done  = '0;

  gcd_rr_sched #(.NREQ(N), .WIDTH(W), .MAX_ITER(MI)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_gcd   (rsp_gcd),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Euclid with a step cap; an unfinished reduction means the cap was hit.
  task automatic ref_gcd(input logic [31:0] a0, input logic [31:0] b0,
                         output logic [31:0] g, output logic e, output int k);
    logic [31:0] a, b, t;
    a = a0; b = b0; k = 0;
    while (b != 0 && k < MI) begin
      t = a % b; a = b; b = t; k++;
    end
    g = a;
    e = (b != 0);
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int o = 0; o < N; o++)
      if (v[(p + o) % N]) return (p + o) % N;
    return 0;
  endfunction

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b);
    req_valid[r]       = 1'b1;
    req_a[r*W +: W]    = a;
    req_b[r*W +: W]    = b;
  endtask

  // Serves all pending requests; called and returns just after a rising edge.
  task automatic serve(input int stall);
    int          owner, t0, k, waited, budget;
    logic [31:0] eg;
    logic        ee;
    logic [N-1:0] rnd;
    bit          active, seen;
    active = 0; seen = 0; budget = 0; owner = 0; t0 = 0; k = 0; waited = 0;
    eg = '0; ee = 1'b0;
    while ((req_valid != 0 || active) && budget < 2000) begin
      @(negedge clk);
      budget++;
      if (!active) begin
        owner = pick(req_valid, m_ptr);
        check("idle_busy", 32'(busy), 32'd0);
        check("grant", 32'(req_ready), 32'(4'b1 << owner));
        ref_gcd(req_a[owner*W +: W], req_b[owner*W +: W], eg, ee, k);
        t0 = cyc; active = 1; seen = 0; waited = 0;
        @(posedge clk);
        #1 req_valid[owner] = 1'b0;
      end else begin
        check("ready_quiet", 32'(req_ready), 32'd0);
        if (rsp_valid != 0) begin
          if (!seen) check("latency", 32'(cyc - t0), 32'(k + 2));
          seen = 1;
          check("rsp_owner", 32'(rsp_valid), 32'(4'b1 << owner));
          check("rsp_gcd", rsp_gcd, eg);
          check("rsp_err", 32'(rsp_err), 32'(ee));
          rnd = N'($urandom);
          if (waited < stall) begin
            waited++;
            rsp_ready = rnd & ~(N'(1) << owner);
          end else begin
            rsp_ready = rnd | (N'(1) << owner);
            @(posedge clk);
            #1;
            m_done++;
            m_ptr = (owner + 1) % N;
            active = 0;
            check("done_cnt", 32'(done_cnt), 32'(m_done));
            check("rsp_drop", 32'(rsp_valid), 32'd0);
            rsp_ready = '0;
          end
        end else if (!seen && (cyc - t0) > k + 2) begin
          check("latency", 32'(cyc - t0), 32'(k + 2));
          active = 0;
          req_valid = '0;
        end
      end
    end
    check("serve_bound", 32'(budget < 2000), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_gcd", rsp_gcd, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_cnt), 32'd0);
    rst = 1'b0;

    set_req(0, 12, 8);
    serve(0);

    for (int r = 0; r < N; r++) set_req(r, 48, 18);
    serve(1);
    set_req(0, 48, 18);
    serve(0);

    set_req(1, 7, 0);  serve(0);
    set_req(2, 0, 9);  serve(0);
    set_req(3, 0, 0);  serve(0);

    set_req(2, 89, 55);
    serve(5);

    // Abort a job mid-RUN with a one-cycle reset.
    set_req(2, 1071, 462);
    @(negedge clk);
    check("abort_accept", 32'(req_ready), 32'h4);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done_cnt), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    m_ptr = 0; m_done = '0;
    set_req(3, 5, 3);
    set_req(0, 20, 15);
    serve(0);

    for (int t = 0; t < 20; t++) begin
      logic [N-1:0] mask;
      mask = N'($urandom_range(1, 15));
      for (int r = 0; r < N; r++) begin
        if (mask[r]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(r, $urandom_range(0, 200), $urandom_range(0, 200));
          else
            set_req(r, $urandom, $urandom);
        end
      end
      serve($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gcd_rr_sched.md
GCD_RR_SCHED -- requirements
Module: gcd_rr_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-003 SHALL have parameter MAX_ITER, default 64, cap on modulo steps per job.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port req_valid  in  NREQ  per-requester job request.
REQ-007 SHALL have port req_ready  out  NREQ  per-requester accept strobe.
REQ-008 SHALL have port req_a  in  NREQ*WIDTH  operand A; slice i belongs to requester i.
REQ-009 SHALL have port req_b  in  NREQ*WIDTH  operand B; slice i belongs to requester i.
REQ-010 SHALL have port rsp_valid  out  NREQ  result valid, one-hot to the job owner.
REQ-011 SHALL have port rsp_ready  in  NREQ  per-requester result accept.
REQ-012 SHALL have port rsp_gcd  out  WIDTH  result, shared by all requesters.
REQ-013 SHALL have port rsp_err  out  1  iteration cap hit; qualified by rsp_valid.
REQ-014 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-015 SHALL have port done_cnt  out  16  completed-job counter; wraps 0xFFFF->0.

Function
REQ-016 SHALL implement the states IDLE, RUN and RESP.
REQ-017 IDLE: if any req_valid, grant round-robin starting at rr_ptr, assert req_ready[grant] for exactly that cycle, latch a_q<=A, b_q<=B, iter<=0, owner<=grant, go RUN.
REQ-018 IDLE: SHALL otherwise hold, with req_ready all-zero.
REQ-019 req_ready SHALL be at most one-hot and SHALL assert only in IDLE.
REQ-020 RUN, per cycle: if b_q==0 go RESP with result a_q, err=0.
REQ-021 RUN, per cycle: else if iter==MAX_ITER go RESP with result a_q, err=1.
REQ-022 RUN, per cycle: else a_q<=b_q, b_q<=a_q mod b_q, iter++.
REQ-023 Latency SHALL be k+2 cycles from the accept cycle T to the first rsp_valid cycle, where k is the number of modulo steps (12,8 -> k=2 -> rsp_valid at T+4).
REQ-024 RESP: rsp_valid[owner]=1, other bits 0; rsp_gcd and rsp_err held stable until rsp_ready[owner].
REQ-025 RESP handshake cycle: go IDLE, rr_ptr<=owner+1 mod NREQ, done_cnt++.
REQ-026 rsp_ready bits of non-owners SHALL be ignored.
REQ-027 Zero operands: gcd(a,0)=a; gcd(0,b)=b (one step); gcd(0,0)=0 with err=0.
REQ-028 Arithmetic SHALL be unsigned at WIDTH bits; iter width SHALL be clog2(MAX_ITER+1).
REQ-029 One idle cycle SHALL separate a response handshake from the next accept; a request held valid during RESP SHALL be accepted in the following IDLE cycle.
REQ-030 Requests arriving during RUN/RESP SHALL NOT be accepted.
REQ-031 Requesters SHALL hold req_valid and operands until req_ready (protocol rule); the block SHALL sample operands only in the accept cycle.

Reset
REQ-032 rst SHALL force IDLE, rr_ptr=0, a_q=b_q=0, iter=0, owner=0, done_cnt=0 on the next edge.
REQ-033 After reset, req_ready, rsp_valid, rsp_gcd, rsp_err and busy SHALL all be 0.
REQ-034 rst asserted in RUN or RESP SHALL abort the job with no response issued; done_cnt SHALL be cleared.

Structure
REQ-035 Shared package gcd_pkg SHALL hold the state enum (IDLE/RUN/RESP), the default WIDTH and the default MAX_ITER.
REQ-036 The datapath (a_q/b_q registers, modulo, zero detect, iteration counter) SHALL be sub-module gcd_step_core.
REQ-037 Arbitration, state machine and handshakes SHALL remain in gcd_rr_sched.

Verification
REQ-038 Single job: req0 A=12, B=8 accepted at T -> rsp_valid[0] at T+4, rsp_gcd=4, err=0, done_cnt=1.
REQ-039 Fairness: all four valid continuously, each with A=48, B=18 -> grant order 0,1,2,3,0, each rsp_gcd=6, rsp_valid to the matching owner only.
REQ-040 Zero cases: (7,0)->7 at T+2; (0,9)->9; (0,0)->0; err=0 in all three.
REQ-041 Cap: MAX_ITER=4, A=89, B=55 -> rsp_err=1, rsp_valid at T+6; stall rsp_ready 5 cycles -> outputs stable throughout.
REQ-042 Reset mid-RUN: rst for one cycle at T+2 of job (1071,462) -> no rsp_valid, busy=0, done_cnt=0, next job granted to requester 0.
